// File: rtl/vram_fill_arbiter_pkg.sv
// vram_fill_arbiter_pkg
//   Shared types and constants for the VRAM fill engine:
//   - vram_address_t : VRAM byte address type used across the GPU path
//   - fill_reg_e     : register file indices seen by the CPU
//   - CTRL_*         : bit positions inside the control register
//   - fill_state_e   : fill engine state encoding
package vram_fill_arbiter_pkg;

  localparam int unsigned VRAM_ADDR_W_DEF = 12;

  typedef logic [VRAM_ADDR_W_DEF-1:0] vram_address_t;

  typedef enum logic [2:0] {
    REG_ADDR_LO = 3'd0,
    REG_ADDR_HI = 3'd1,
    REG_LEN_LO  = 3'd2,
    REG_LEN_HI  = 3'd3,
    REG_VALUE   = 3'd4,
    REG_CTRL    = 3'd5
  } fill_reg_e;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_CLR_IRQ = 2;
  localparam int unsigned CTRL_GATE_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter
//   Hardware VRAM fill engine sharing the CPU-side VRAM write port.
//   The CPU programs start address, length and fill byte, then starts the
//   engine, which writes one byte per cycle (optionally only in vblank).
//   CPU VRAM accesses always take the port; the fill stalls that cycle.
// Ports:
//   cpu_clk, rst               clock, synchronous active-high reset
//   reg_sel_i/reg_wen_i/reg_data_i   register file write port
//   cpu_vram_*_i               CPU VRAM access (has priority)
//   in_vblank_i                GPU vblank level (fill gate)
//   vram_*_o                   muxed VRAM port towards the GPU
//   busy_o                     fill in progress (running or gated)
//   done_irq_o                 sticky completion flag
module vram_fill_arbiter
  import vram_fill_arbiter_pkg::*;
#(
  parameter int unsigned VRAM_ADDR_W = 12,
  parameter int unsigned LEN_W       = 12
) (
  input  logic                   cpu_clk,
  input  logic                   rst,
  input  logic [2:0]             reg_sel_i,
  input  logic                   reg_wen_i,
  input  logic [7:0]             reg_data_i,
  input  logic                   cpu_vram_req_i,
  input  logic                   cpu_vram_wen_i,
  input  logic [VRAM_ADDR_W-1:0] cpu_vram_address_i,
  input  logic [7:0]             cpu_vram_data_i,
  input  logic                   in_vblank_i,
  output logic                   vram_select_o,
  output logic                   vram_wen_o,
  output logic [VRAM_ADDR_W-1:0] vram_address_o,
  output logic [7:0]             vram_data_o,
  output logic                   busy_o,
  output logic                   done_irq_o
);

  logic [7:0]             addr_lo_q;
  logic [3:0]             addr_hi_q;
  logic [7:0]             len_lo_q;
  logic [3:0]             len_hi_q;
  logic [7:0]             value_q;
  logic                   gate_en_q;

  fill_state_e            state_q, state_d;
  logic [VRAM_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic                   done_irq_q, done_irq_d;

  logic                   busy;
  logic                   ctrl_wr;
  logic                   start;
  logic                   abort;
  logic                   clr_irq;
  logic                   fill_beat;
  logic [VRAM_ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]       start_len;

  assign busy       = (state_q == ST_FILL);
  assign ctrl_wr    = reg_wen_i && (reg_sel_i == REG_CTRL);
  assign start      = ctrl_wr && reg_data_i[CTRL_START];
  assign abort      = ctrl_wr && reg_data_i[CTRL_ABORT];
  assign clr_irq    = ctrl_wr && reg_data_i[CTRL_CLR_IRQ];
  assign start_addr = VRAM_ADDR_W'({addr_hi_q, addr_lo_q});
  assign start_len  = LEN_W'({len_hi_q, len_lo_q});

  // A beat only happens when the CPU leaves the port free and the gate is open.
  assign fill_beat  = busy && !cpu_vram_req_i && (!gate_en_q || in_vblank_i);

  // Register file: setup registers are frozen while a fill runs; gate_en
  // follows every control write regardless of state.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      addr_lo_q <= '0;
      addr_hi_q <= '0;
      len_lo_q  <= '0;
      len_hi_q  <= '0;
      value_q   <= '0;
      gate_en_q <= 1'b0;
    end else begin
      if (reg_wen_i && !busy) begin
        case (reg_sel_i)
          REG_ADDR_LO: addr_lo_q <= reg_data_i;
          REG_ADDR_HI: addr_hi_q <= reg_data_i[3:0];
          REG_LEN_LO:  len_lo_q  <= reg_data_i;
          REG_LEN_HI:  len_hi_q  <= reg_data_i[3:0];
          REG_VALUE:   value_q   <= reg_data_i;
          default:     ;
        endcase
      end
      if (ctrl_wr) begin
        gate_en_q <= reg_data_i[CTRL_GATE_EN];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (start_len == '0) begin
            state_d = ST_DONE;
          end else begin
            cur_addr_d  = start_addr;
            remaining_d = start_len;
            state_d     = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (abort) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end else if (fill_beat) begin
          cur_addr_d  = cur_addr_q + VRAM_ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The flag is raised on the edge that enters DONE, so it rises together
  // with busy_o falling; a simultaneous clear loses to the set.
  always_comb begin
    done_irq_d = done_irq_q;
    if (clr_irq) begin
      done_irq_d = 1'b0;
    end
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      done_irq_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      done_irq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      done_irq_q  <= done_irq_d;
    end
  end

  always_comb begin
    vram_select_o  = 1'b0;
    vram_wen_o     = 1'b0;
    vram_address_o = '0;
    vram_data_o    = '0;
    if (cpu_vram_req_i) begin
      vram_select_o  = 1'b1;
      vram_wen_o     = cpu_vram_wen_i;
      vram_address_o = cpu_vram_address_i;
      vram_data_o    = cpu_vram_data_i;
    end else if (fill_beat) begin
      vram_select_o  = 1'b1;
      vram_wen_o     = 1'b1;
      vram_address_o = cur_addr_q;
      vram_data_o    = value_q;
    end
  end

  assign busy_o     = busy;
  assign done_irq_o = done_irq_q;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
module tb_vram_fill_arbiter;
  import vram_fill_arbiter_pkg::*;

  logic        cpu_clk;
  logic        rst;
  logic [2:0]  reg_sel_i;
  logic        reg_wen_i;
  logic [7:0]  reg_data_i;
  logic        cpu_vram_req_i;
  logic        cpu_vram_wen_i;
  logic [11:0] cpu_vram_address_i;
  logic [7:0]  cpu_vram_data_i;
  logic        in_vblank_i;
  logic        vram_select_o;
  logic        vram_wen_o;
  logic [11:0] vram_address_o;
  logic [7:0]  vram_data_o;
  logic        busy_o;
  logic        done_irq_o;

  vram_fill_arbiter #(.VRAM_ADDR_W(12), .LEN_W(12)) dut (
    .cpu_clk            (cpu_clk),
    .rst                (rst),
    .reg_sel_i          (reg_sel_i),
    .reg_wen_i          (reg_wen_i),
    .reg_data_i         (reg_data_i),
    .cpu_vram_req_i     (cpu_vram_req_i),
    .cpu_vram_wen_i     (cpu_vram_wen_i),
    .cpu_vram_address_i (cpu_vram_address_i),
    .cpu_vram_data_i    (cpu_vram_data_i),
    .in_vblank_i        (in_vblank_i),
    .vram_select_o      (vram_select_o),
    .vram_wen_o         (vram_wen_o),
    .vram_address_o     (vram_address_o),
    .vram_data_o        (vram_data_o),
    .busy_o             (busy_o),
    .done_irq_o         (done_irq_o)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        rst;
    logic        rw;
    logic [2:0]  rs;
    logic [7:0]  rd;
    logic        cr;
    logic        cw;
    logic [11:0] ca;
    logic [7:0]  cd;
    logic        vb;
    logic        e_sel;
    logic        e_wen;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
    logic        e_busy;
    logic        e_done;
  } step_t;

  step_t tbl[$];
  int    checks = 0;
  int    passed = 0;

  task automatic add(input logic r, input logic rw, input logic [2:0] rs, input logic [7:0] rd,
                     input logic cr, input logic cw, input logic [11:0] ca, input logic [7:0] cd,
                     input logic vb, input logic es, input logic ew, input logic [11:0] ea,
                     input logic [7:0] ed, input logic eb, input logic edn);
    step_t s;
    s.rst = r;  s.rw = rw; s.rs = rs; s.rd = rd;
    s.cr = cr;  s.cw = cw; s.ca = ca; s.cd = cd; s.vb = vb;
    s.e_sel = es; s.e_wen = ew; s.e_addr = ea; s.e_data = ed;
    s.e_busy = eb; s.e_done = edn;
    tbl.push_back(s);
  endtask

  // Register write in a cycle where no fill beat is expected.
  task automatic wr(input logic [2:0] rs, input logic [7:0] rd, input logic eb, input logic edn);
    add(0, 1, rs, rd, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, eb, edn);
  endtask

  task automatic idle(input logic eb, input logic edn);
    add(0, 0, 3'd0, 8'h00, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, eb, edn);
  endtask

  task automatic beat(input logic [11:0] a, input logic [7:0] d, input logic vb, input logic edn);
    add(0, 0, 3'd0, 8'h00, 0, 0, 12'h000, 8'h00, vb, 1, 1, a, d, 1, edn);
  endtask

  task automatic apply(input step_t s, input int idx);
    @(negedge cpu_clk);
    rst                = s.rst;
    reg_wen_i          = s.rw;
    reg_sel_i          = s.rs;
    reg_data_i         = s.rd;
    cpu_vram_req_i     = s.cr;
    cpu_vram_wen_i     = s.cw;
    cpu_vram_address_i = s.ca;
    cpu_vram_data_i    = s.cd;
    in_vblank_i        = s.vb;
    #1;
    checks++;
    if ({vram_select_o, vram_wen_o, vram_address_o, vram_data_o, busy_o, done_irq_o} ===
        {s.e_sel, s.e_wen, s.e_addr, s.e_data, s.e_busy, s.e_done}) begin
      passed++;
    end else begin
      $display("FAIL step%0d: got sel=%b wen=%b addr=%h data=%h busy=%b done=%b, want sel=%b wen=%b addr=%h data=%h busy=%b done=%b",
               idx, vram_select_o, vram_wen_o, vram_address_o, vram_data_o, busy_o, done_irq_o,
               s.e_sel, s.e_wen, s.e_addr, s.e_data, s.e_busy, s.e_done);
    end
  endtask

  initial begin
    rst = 1'b1; reg_wen_i = 1'b0; reg_sel_i = '0; reg_data_i = '0;
    cpu_vram_req_i = 1'b0; cpu_vram_wen_i = 1'b0; cpu_vram_address_i = '0;
    cpu_vram_data_i = '0; in_vblank_i = 1'b0;

    // Idle passthrough of CPU accesses; idle vblank produces nothing.
    add(0, 0, 3'd0, 8'h00, 1, 0, 12'h123, 8'h00, 0, 1, 0, 12'h123, 8'h00, 0, 0);
    add(0, 0, 3'd0, 8'h00, 1, 1, 12'hABC, 8'h5A, 0, 1, 1, 12'hABC, 8'h5A, 0, 0);
    add(0, 0, 3'd0, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'h000, 8'h00, 0, 0);

    // Basic fill 0x100, len 4, 0xAA; addr_hi upper nibble dropped; addr_lo write while busy ignored.
    wr(REG_ADDR_LO, 8'h00, 0, 0); wr(REG_ADDR_HI, 8'hF1, 0, 0);
    wr(REG_LEN_LO, 8'h04, 0, 0);  wr(REG_LEN_HI, 8'h00, 0, 0);
    wr(REG_VALUE, 8'hAA, 0, 0);   wr(REG_CTRL, 8'h01, 0, 0);
    beat(12'h100, 8'hAA, 0, 0);
    add(0, 1, REG_ADDR_LO, 8'h55, 0, 0, 12'h000, 8'h00, 0, 1, 1, 12'h101, 8'hAA, 1, 0);
    beat(12'h102, 8'hAA, 0, 0); beat(12'h103, 8'hAA, 0, 0);
    idle(0, 1); idle(0, 1);

    // Same fill with a CPU write stealing the third cycle.
    wr(REG_CTRL, 8'h04, 0, 1); wr(REG_CTRL, 8'h01, 0, 0);
    beat(12'h100, 8'hAA, 0, 0); beat(12'h101, 8'hAA, 0, 0);
    add(0, 0, 3'd0, 8'h00, 1, 1, 12'h555, 8'h5A, 0, 1, 1, 12'h555, 8'h5A, 1, 0);
    beat(12'h102, 8'hAA, 0, 0); beat(12'h103, 8'hAA, 0, 0);
    idle(0, 1);

    // Address wrap 0xFFE..0x000.
    wr(REG_CTRL, 8'h04, 0, 1); wr(REG_ADDR_LO, 8'hFE, 0, 0); wr(REG_ADDR_HI, 8'h0F, 0, 0);
    wr(REG_LEN_LO, 8'h03, 0, 0); wr(REG_VALUE, 8'h5C, 0, 0); wr(REG_CTRL, 8'h01, 0, 0);
    beat(12'hFFE, 8'h5C, 0, 0); beat(12'hFFF, 8'h5C, 0, 0); beat(12'h000, 8'h5C, 0, 0);
    idle(0, 1);

    // Vblank gating: 10 closed cycles, then writes in vblank.
    wr(REG_CTRL, 8'h04, 0, 1); wr(REG_ADDR_LO, 8'h00, 0, 0); wr(REG_ADDR_HI, 8'h02, 0, 0);
    wr(REG_LEN_LO, 8'h02, 0, 0); wr(REG_VALUE, 8'h3C, 0, 0); wr(REG_CTRL, 8'h09, 0, 0);
    for (int i = 0; i < 10; i++) idle(1, 0);
    beat(12'h200, 8'h3C, 1, 0); beat(12'h201, 8'h3C, 1, 0);
    idle(0, 1);

    // len=0 start, clr_irq, then start+abort together.
    wr(REG_CTRL, 8'h04, 0, 1); wr(REG_LEN_LO, 8'h00, 0, 0); wr(REG_CTRL, 8'h01, 0, 0);
    idle(0, 1); idle(0, 1);
    wr(REG_CTRL, 8'h04, 0, 1); idle(0, 0);
    wr(REG_LEN_LO, 8'h05, 0, 0); wr(REG_CTRL, 8'h03, 0, 0);
    idle(0, 0); idle(0, 0);

    // len=8 aborted during the third beat.
    wr(REG_ADDR_LO, 8'h40, 0, 0); wr(REG_ADDR_HI, 8'h00, 0, 0);
    wr(REG_LEN_LO, 8'h08, 0, 0);  wr(REG_VALUE, 8'h77, 0, 0); wr(REG_CTRL, 8'h01, 0, 0);
    beat(12'h040, 8'h77, 0, 0); beat(12'h041, 8'h77, 0, 0);
    add(0, 1, REG_CTRL, 8'h02, 0, 0, 12'h000, 8'h00, 0, 1, 1, 12'h042, 8'h77, 1, 0);
    idle(0, 0); idle(0, 0);

    // Reset state.
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    checks++;
    if ({vram_select_o, vram_wen_o, vram_address_o, vram_data_o, busy_o, done_irq_o} === 24'h0)
      passed++;
    else
      $display("FAIL reset_state: got sel=%b wen=%b addr=%h data=%h busy=%b done=%b, want all 0",
               vram_select_o, vram_wen_o, vram_address_o, vram_data_o, busy_o, done_irq_o);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset mid-fill: set done via a 1-byte fill, start an 8-byte fill, reset on its second beat.
    tbl.delete();
    wr(REG_LEN_LO, 8'h01, 0, 0); wr(REG_CTRL, 8'h01, 0, 0);
    beat(12'h040, 8'h77, 0, 0);
    idle(0, 1);
    wr(REG_LEN_LO, 8'h08, 0, 1); wr(REG_CTRL, 8'h01, 0, 1);
    beat(12'h040, 8'h77, 0, 1);
    add(1, 0, 3'd0, 8'h00, 0, 0, 12'h000, 8'h00, 0, 1, 1, 12'h041, 8'h77, 1, 1);
    idle(0, 0); idle(0, 0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1000 + i);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end

endmodule
